// File: rtl/hyper_vector_iter.sv
// Iterative hyperbolic CORDIC in vectoring mode: drives Y to zero while Z
// accumulates atanh(Y0/X0); one micro-rotation per clock, valid/ready on both sides.
module hyper_vector_iter #(
  parameter int DWIDTH    = 32,
  parameter int FRA_WIDTH = 28,
  parameter int NITER     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] Xin,
  input  logic [DWIDTH-1:0] Yin,
  input  logic [DWIDTH-1:0] Zin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] Xout,
  output logic [DWIDTH-1:0] Yout,
  output logic [DWIDTH-1:0] Zout,
  output logic              out_range
);

  localparam int KW    = $clog2(NITER + 1);
  localparam int GUARD = 32;
  localparam int TSIZE = 1 << KW;

  // atanh(2^-k) = sum x^(2n+1)/(2n+1), evaluated with GUARD extra bits then rounded.
  function automatic logic [DWIDTH-1:0] atanh_fix(input int k);
    logic [127:0] one;
    logic [127:0] acc;
    int sh;
    one = 128'd1 << (FRA_WIDTH + GUARD);
    acc = '0;
    for (int n = 0; n < 64; n++) begin
      sh = k * (2 * n + 1);
      if (sh <= FRA_WIDTH + GUARD)
        acc = acc + (one >> sh) / 128'(2 * n + 1);
    end
    acc = (acc + (128'd1 << (GUARD - 1))) >> GUARD;
    return acc[DWIDTH-1:0];
  endfunction

  function automatic logic is_rep(input logic [KW-1:0] k);
    int ki;
    ki = int'(k);
    return (ki == 4) || (ki == 13) || (ki == 40);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic signed [DWIDTH-1:0] x_reg, y_reg, z_reg;
  logic [KW-1:0]            k_reg;
  logic                     rep_reg;
  logic                     valid_reg;
  logic                     range_reg;

  logic [DWIDTH-1:0] tab [0:TSIZE-1];

  generate
    for (genvar gi = 0; gi < TSIZE; gi++) begin : g_tab
      if (gi >= 1 && gi <= NITER) begin : g_on
        localparam logic [DWIDTH-1:0] TK = atanh_fix(gi);
        assign tab[gi] = TK;
      end else begin : g_off
        assign tab[gi] = '0;
      end
    end
  endgenerate

  logic                     neg;
  logic                     hold_k;
  logic                     last;
  logic signed [DWIDTH-1:0] x_sh, y_sh, t_k;
  logic signed [DWIDTH-1:0] x_nx, y_nx, z_nx;

  always_comb begin
    neg    = y_reg[DWIDTH-1];
    x_sh   = x_reg >>> k_reg;
    y_sh   = y_reg >>> k_reg;
    t_k    = $signed(tab[k_reg]);
    hold_k = is_rep(k_reg) && !rep_reg;
    last   = (k_reg == KW'(NITER)) && !hold_k;
    if (neg) begin
      x_nx = x_reg + y_sh;
      y_nx = y_reg + x_sh;
      z_nx = z_reg - t_k;
    end else begin
      x_nx = x_reg - y_sh;
      y_nx = y_reg - x_sh;
      z_nx = z_reg + t_k;
    end
  end

  // One extra bit so |Yin| of the most negative word and Xin - Xin/4 cannot wrap.
  logic signed [DWIDTH:0] xin_w, yin_w, yin_abs, xin_lim;
  logic                   range_bad;

  always_comb begin
    xin_w     = $signed({Xin[DWIDTH-1], Xin});
    yin_w     = $signed({Yin[DWIDTH-1], Yin});
    yin_abs   = yin_w[DWIDTH] ? -yin_w : yin_w;
    xin_lim   = xin_w - (xin_w >>> 2);
    range_bad = xin_w[DWIDTH] | (Xin == '0) | (yin_abs > xin_lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      k_reg     <= '0;
      rep_reg   <= 1'b0;
      valid_reg <= 1'b0;
      range_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= $signed(Xin);
            y_reg     <= $signed(Yin);
            z_reg     <= $signed(Zin);
            k_reg     <= KW'(1);
            rep_reg   <= 1'b0;
            range_reg <= range_bad;
          end
        end
        RUN: begin
          x_reg <= x_nx;
          y_reg <= y_nx;
          z_reg <= z_nx;
          if (hold_k) begin
            rep_reg <= 1'b1;
          end else begin
            rep_reg <= 1'b0;
            k_reg   <= k_reg + KW'(1);
          end
          if (last) valid_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) valid_reg <= 1'b0;
        end
        default: valid_reg <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = valid_reg;
  assign Xout      = x_reg;
  assign Yout      = y_reg;
  assign Zout      = z_reg;
  assign out_range = range_reg;

endmodule

// File: tb/tb_hyper_vector_iter.sv
// Scoreboard bench for hyper_vector_iter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_hyper_vector_iter;

  localparam int     DW  = 32;
  localparam int     LAT = 18;
  localparam longint TOL = 64'd16384;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_range;
  logic [DW-1:0] Xin, Yin, Zin, Xout, Yout, Zout;

  always #5 clk = ~clk;

  hyper_vector_iter #(.DWIDTH(32), .FRA_WIDTH(28), .NITER(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Xin(Xin), .Yin(Yin), .Zin(Zin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Xout(Xout), .Yout(Yout), .Zout(Zout), .out_range(out_range)
  );

  typedef struct {
    longint x;
    longint y;
    longint z;
    bit     rng;
    bit     vals;
    int     tag;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  function automatic bit near(input longint a, input longint b);
    return (a - b <= TOL) && (b - a <= TOL);
  endfunction

  // Monitor: latency from the accepting edge and value compare on each output handshake.
  bit     prev_valid = 1'b0;
  bit     acc_pend   = 1'b0;
  longint acc_cyc    = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      acc_pend   = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc  = cyc + 1;
        acc_pend = 1'b1;
      end
      if (out_valid && !prev_valid) begin
        check(acc_pend && (cyc - acc_cyc == LAT), "latency", cyc - acc_cyc, LAT);
        acc_pend = 1'b0;
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("result tag=%0d X=%0d Y=%0d Z=%0d range=%0b", e.tag,
                   $signed(Xout), $signed(Yout), $signed(Zout), out_range);
          check(out_range == e.rng, $sformatf("range_t%0d", e.tag), longint'(out_range), longint'(e.rng));
          if (e.vals) begin
            check(near(longint'($signed(Xout)), e.x), $sformatf("xout_t%0d", e.tag), longint'($signed(Xout)), e.x);
            check(near(longint'($signed(Yout)), e.y), $sformatf("yout_t%0d", e.tag), longint'($signed(Yout)), e.y);
            check(near(longint'($signed(Zout)), e.z), $sformatf("zout_t%0d", e.tag), longint'($signed(Zout)), e.z);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] xi, input logic [DW-1:0] yi, input logic [DW-1:0] zi,
                      input bit push, input exp_t e);
    bit ok;
    ok = 1'b0;
    if (push) exp_q.push_back(e);
    in_valid = 1'b1;
    Xin = xi;
    Yin = yi;
    Zin = zi;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(1'b0, "accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check(1'b0, "result_timeout", longint'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  function automatic exp_t mk(input longint x, input longint y, input longint z,
                              input bit rng, input bit vals, input int tag);
    exp_t e;
    e.x = x; e.y = y; e.z = z; e.rng = rng; e.vals = vals; e.tag = tag;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sx, sy, sz;
    logic          sr;
    bit            seen;
    exp_t          e1;

    e1 = mk(192523800, 0, 147453245, 1'b0, 1'b1, 1);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Xin = '0; Yin = '0; Zin = '0;
    repeat (3) @(posedge clk);
    #1;
    check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
    check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    check(Xout == '0 && Yout == '0 && Zout == '0, "rst_data", longint'(Xout | Yout | Zout), 0);
    check(out_range == 1'b0, "rst_range", longint'(out_range), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // atanh(0.5), atanh(-0.5)+0.25, Y=0 sign rule, |Y| exactly at the range limit
    send(32'h1000_0000, 32'h0800_0000, 32'h0000_0000, 1'b1, e1);
    wait_result();
    send(32'h1000_0000, 32'hF800_0000, 32'h0400_0000, 1'b1, mk(192523800, 0, -80344381, 1'b0, 1'b1, 2));
    wait_result();
    send(32'h0C00_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, mk(166730501, 0, 0, 1'b0, 1'b1, 3));
    wait_result();
    send(32'h1000_0000, 32'h0C00_0000, 32'h0000_0000, 1'b1, mk(147042494, 0, 261175639, 1'b0, 1'b1, 4));
    wait_result();
    send(32'h1000_0000, 32'd241591910, 32'h0000_0000, 1'b1, mk(0, 0, 0, 1'b1, 1'b0, 5));
    wait_result();
    send(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, mk(0, 0, 0, 1'b1, 1'b0, 6));
    wait_result();

    // Backpressure in DONE, then a back-to-back accept right after the handshake
    out_ready = 1'b0;
    send(32'h1000_0000, 32'h0800_0000, 32'h0000_0000, 1'b1, mk(192523800, 0, 147453245, 1'b0, 1'b1, 7));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(seen, "bp_done_reached", longint'(seen), 1);
    sx = Xout; sy = Yout; sz = Zout; sr = out_range;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      Xin = 32'h0400_0000; Yin = 32'h0200_0000; Zin = 32'h0100_0000;
      @(posedge clk);
      #1;
      check(out_valid == 1'b1 && in_ready == 1'b0, $sformatf("bp_hs_%0d", i),
            longint'({out_valid, in_ready}), 2);
      check(Xout == sx && Yout == sy && Zout == sz && out_range == sr, $sformatf("bp_hold_%0d", i),
            longint'($signed(Zout)), longint'($signed(sz)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check(out_valid == 1'b0 && in_ready == 1'b1, "bp_release", longint'({out_valid, in_ready}), 1);
    send(32'h1000_0000, 32'hF800_0000, 32'h0400_0000, 1'b1, mk(192523800, 0, -80344381, 1'b0, 1'b1, 8));
    wait_result();

    // Asynchronous reset during iteration 7, then a clean rerun of the first case
    send(32'h1000_0000, 32'h0800_0000, 32'h0000_0000, 1'b0, e1);
    repeat (6) @(posedge clk);
    #2;
    check(out_valid == 1'b0 && in_ready == 1'b0, "mid_op_busy", longint'({out_valid, in_ready}), 0);
    rst_n = 1'b0;
    #1;
    check(Xout == '0 && Yout == '0 && Zout == '0, "async_rst_data", longint'($signed(Xout)), 0);
    check(out_valid == 1'b0 && out_range == 1'b0 && in_ready == 1'b1, "async_rst_ctrl",
          longint'({out_valid, out_range, in_ready}), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e1.tag = 9;
    send(32'h1000_0000, 32'h0800_0000, 32'h0000_0000, 1'b1, e1);
    wait_result();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
